// File: rtl/linebuf_seq_pkg.sv
// Shared types for the line-buffer sequencer: FSM state encoding and counter sizing.
package linebuf_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_PAD_BOT   = 3'd2,
    ST_NEXT_FMAP = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

  // Row/col counters must reach the last pad row, one bit of headroom kept.
  function automatic int unsigned cnt_width(input int unsigned x_dim, input int unsigned pad);
    return $clog2(x_dim + pad) + 1;
  endfunction

endpackage

// File: rtl/seq_rowcol_counter.sv
// Column/row position within one feature map, including the bottom pad rows.
module seq_rowcol_counter
  import linebuf_seq_pkg::*;
#(
  parameter int unsigned X_DIM = 28,
  parameter int unsigned PAD   = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic col_wrap,
  output logic last_row
);

  localparam int unsigned CNT_W = cnt_width(X_DIM, PAD);
  localparam logic [CNT_W-1:0] COL_LAST      = CNT_W'(X_DIM - 1);
  localparam logic [CNT_W-1:0] ROW_FILL_LAST = CNT_W'(X_DIM - 1);
  localparam logic [CNT_W-1:0] ROW_LAST      = CNT_W'(X_DIM + PAD - 1);

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  assign col_wrap = inc && (r_col == COL_LAST);
  // Fill rows and pad rows never overlap, so one flag serves both phases.
  assign last_row = (r_row == ROW_FILL_LAST) || (r_row == ROW_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/linebuf_sequencer.sv
// Sequences pixel writes into the line buffer per feature map, adding bottom zero-pad rows.
// Optional LINEBUF_SEQ_ABORT_EN adds an abort input that returns the FSM to idle.
module linebuf_sequencer
  import linebuf_seq_pkg::*;
#(
  parameter int unsigned KER_SIZE    = 3,
  parameter int unsigned INPUT_X_DIM = 28,
  parameter int unsigned PAD         = 1,
  parameter int unsigned NFMAPS      = 3,
  localparam int unsigned FMAP_W     = (NFMAPS > 1) ? $clog2(NFMAPS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
`ifdef LINEBUF_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              win_ready,
  input  logic              mac_ready,
  output logic              lb_valid,
  output logic              lb_pad_zero,
  output logic [FMAP_W-1:0] fmap_idx,
  output logic              busy,
  output logic              done
);

  if (KER_SIZE > INPUT_X_DIM + PAD) begin : g_ker_too_big
    $error("KER_SIZE exceeds padded feature map height");
  end

  localparam logic [FMAP_W-1:0] FMAP_LAST = FMAP_W'(NFMAPS - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [FMAP_W-1:0] r_fmap_idx;
  logic              r_busy;
  logic              r_done;
  logic              w_stall;
  logic              w_cnt_clr;
  logic              w_fmap_inc;
  logic              w_fmap_clr;
  logic              w_col_wrap;
  logic              w_last_row;

  // Window full and MAC not draining: hold the line buffer still.
  assign w_stall = win_ready && !mac_ready;

  seq_rowcol_counter #(
    .X_DIM (INPUT_X_DIM),
    .PAD   (PAD)
  ) u_rowcol (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (w_cnt_clr),
    .inc      (lb_valid),
    .col_wrap (w_col_wrap),
    .last_row (w_last_row)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    src_ready   = 1'b0;
    lb_valid    = 1'b0;
    lb_pad_zero = 1'b0;
    w_cnt_clr   = 1'b0;
    w_fmap_inc  = 1'b0;
    w_fmap_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (start) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        src_ready = !w_stall;
        lb_valid  = src_valid && !w_stall;
        if (w_col_wrap && w_last_row) begin
          w_state_nxt = (PAD > 0) ? ST_PAD_BOT : ST_NEXT_FMAP;
        end
      end
      ST_PAD_BOT: begin
        lb_valid    = !w_stall;
        lb_pad_zero = !w_stall;
        if (w_col_wrap && w_last_row) begin
          w_state_nxt = ST_NEXT_FMAP;
        end
      end
      ST_NEXT_FMAP: begin
        w_cnt_clr = 1'b1;
        if (r_fmap_idx < FMAP_LAST) begin
          w_fmap_inc  = 1'b1;
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_fmap_clr  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
`ifdef LINEBUF_SEQ_ABORT_EN
    // Abort overrides every other transition and skips the done pulse.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
      w_fmap_clr  = 1'b1;
      w_fmap_inc  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fmap_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_fmap_clr) begin
        r_fmap_idx <= '0;
      end else if (w_fmap_inc) begin
        r_fmap_idx <= r_fmap_idx + FMAP_W'(1);
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign fmap_idx = r_fmap_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_linebuf_sequencer.sv
// Scoreboard bench for linebuf_sequencer (X=4, PAD=1, NFMAPS=2, KER_SIZE=3).
module tb_linebuf_sequencer;

  localparam int unsigned X  = 4;
  localparam int unsigned PR = 1;
  localparam int unsigned NF = 2;
  localparam int unsigned KS = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic src_valid = 1'b0;
  logic win_ready = 1'b0;
  logic mac_ready = 1'b0;
  logic src_ready, lb_valid, lb_pad_zero, busy, done;
  logic [0:0] fmap_idx;
`ifdef LINEBUF_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  linebuf_sequencer #(
    .KER_SIZE    (KS),
    .INPUT_X_DIM (X),
    .PAD         (PR),
    .NFMAPS      (NF)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
`ifdef LINEBUF_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .win_ready   (win_ready),
    .mac_ready   (mac_ready),
    .lb_valid    (lb_valid),
    .lb_pad_zero (lb_pad_zero),
    .fmap_idx    (fmap_idx),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic pad;
    int   fmap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_popped = 0;
  int   n_done = 0;
  bit   busy_chk_pending = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each fmap is X*X real pixels followed by PR*X zero-pad pixels.
  task automatic push_layer();
    exp_t e;
    for (int f = 0; f < int'(NF); f++) begin
      for (int i = 0; i < int'(X * X); i++) begin
        e.pad = 1'b0; e.fmap = f; q.push_back(e);
      end
      for (int i = 0; i < int'(PR * X); i++) begin
        e.pad = 1'b1; e.fmap = f; q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (busy_chk_pending) begin
        check("busy_after_done", int'(busy), 0);
        busy_chk_pending = 1'b0;
      end
      if (lb_valid) begin
        if (q.size() == 0) begin
          check("extra_strobe", 1, 0);
        end else begin
          e = q.pop_front();
          n_popped++;
          check("pad_zero", int'(lb_pad_zero), int'(e.pad));
          check("fmap_idx", int'(fmap_idx), e.fmap);
          if (!lb_pad_zero) check("real_strobe_src_valid", int'(src_valid), 1);
        end
      end
      if (src_valid && src_ready) check("accept_strobes", int'(lb_valid), 1);
      if (win_ready && !mac_ready) begin
        check("stall_lb_valid", int'(lb_valid), 0);
        check("stall_src_ready", int'(src_ready), 0);
      end
      if (q.size() > 0 && q[0].pad && busy && !(win_ready && !mac_ready))
        check("pad_strobe_present", int'(lb_valid), 1);
      if (!busy) begin
        check("idle_src_ready", int'(src_ready), 0);
        check("idle_lb_valid", int'(lb_valid), 0);
        check("idle_fmap_idx", int'(fmap_idx), 0);
      end
      if (done) begin
        n_done++;
        check("queue_empty_at_done", q.size(), 0);
        busy_chk_pending = 1'b1;
      end
    end
  end

  task automatic drive(input int mode, input int cyc);
    start = 1'b0;
    case (mode)
      0: begin src_valid = 1'b1; win_ready = 1'b0; mac_ready = 1'b0; end
      1: begin src_valid = cyc[0]; win_ready = 1'b0; mac_ready = 1'b0; end
      2: begin
        src_valid = 1'($urandom);
        win_ready = 1'($urandom);
        mac_ready = 1'($urandom);
      end
      3: begin
        src_valid = 1'b1;
        win_ready = (cyc >= 5 && cyc < 10);
        mac_ready = 1'b0;
      end
      default: begin
        src_valid = 1'b1; win_ready = 1'b0; mac_ready = 1'b0;
        start = (cyc == 7 || cyc == 23);
      end
    endcase
  endtask

  task automatic run_layer(input int mode);
    int d0;
    int cyc;
    d0 = n_done;
    cyc = 0;
    push_layer();
    @(posedge clk); #1;
    drive(mode, 0);
    start = 1'b1;
    @(posedge clk); #1;
    while (n_done == d0 && cyc < 1000) begin
      drive(mode, cyc);
      cyc++;
      @(posedge clk); #1;
    end
    check("layer_done", n_done - d0, 1);
    if (n_done == d0) q.delete();
    start = 1'b0; src_valid = 1'b0; win_ready = 1'b0; mac_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("single_done", n_done - d0, 1);
  endtask

  initial begin
    int p0;
    int d0;
    int cyc;
    start = 1'b1; src_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_lb_valid", int'(lb_valid), 0);
    check("rst_pad_zero", int'(lb_pad_zero), 0);
    check("rst_src_ready", int'(src_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fmap_idx", int'(fmap_idx), 0);
    start = 1'b0; src_valid = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;

    run_layer(0);
    run_layer(1);
    run_layer(3);
    run_layer(4);
    for (int i = 0; i < 4; i++) run_layer(2);

    // Reset at fmap 1 row 2, then a clean layer must follow.
    p0 = n_popped; d0 = n_done; cyc = 0;
    push_layer();
    @(posedge clk); #1 start = 1'b1; src_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while ((n_popped - p0) < 28 && cyc < 500) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("reach_fmap1_row2", n_popped - p0, 28);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_lb_valid", int'(lb_valid), 0);
    check("midrst_src_ready", int'(src_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_fmap_idx", int'(fmap_idx), 0);
    check("midrst_pad_zero", int'(lb_pad_zero), 0);
    check("midrst_done", int'(done), 0);
    q.delete();
    src_valid = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    check("midrst_no_done", n_done - d0, 0);
    p0 = n_popped;
    run_layer(0);
    check("post_rst_strobes", n_popped - p0, 40);

`ifdef LINEBUF_SEQ_ABORT_EN
    p0 = n_popped; d0 = n_done; cyc = 0;
    push_layer();
    @(posedge clk); #1 start = 1'b1; src_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while ((n_popped - p0) < 17 && cyc < 500) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("reach_pad_bot", n_popped - p0, 17);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_lb_valid", int'(lb_valid), 0);
    q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    run_layer(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
